gift_effect_scheduler: RTL and testbench
========================================

Name: gift_effect_scheduler

Overview:
- Sequences power-up effects after the paddle catches a falling gift.
- Takes one caught-gift event at a time over a valid/ready handshake and resolves conflicting effects: INC vs DEC on paddle size, SPU vs SPD on ball speed.
- Runs per-effect frame-count timers and drives the effect state consumed by paddle, ball and shooter logic.
- Sits between the gift movement/collision logic and the game datapath.

Parameters:
- DURATION, 600: effect lifetime in frames (10 s at 60 Hz).
- TMR_W, 10: timer width; must satisfy DURATION < 2^TMR_W.
- SIZE_DEF, 1: default paddle size level.
- SPEED_DEF, 1: default ball speed level.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- lost  in  1  ball lost; level or pulse.
- catch_valid  in  1  caught gift presented.
- catch_kind  in  3  gift kind: 0 INC, 1 DEC, 2 SPU, 3 SPD, 4 HID, 5 SOT, 6 DRP, 7 MUL.
- catch_ready  out  1  scheduler can accept a catch.
- paddle_size  out  2  paddle size level, 0..3.
- speed_lvl  out  2  ball speed level, 0..3.
- hidden  out  1  ball invisible.
- shoot_en  out  1  paddle shooting enabled.
- sticky  out  1  ball sticks to paddle (drop effect).
- multi_req  out  1  one-cycle request to spawn extra balls.
- active  out  5  timer running: bit0 size, bit1 speed, bit2 hide, bit3 shoot, bit4 sticky.

Behaviour:
- Reset (async, active-high): FSM IDLE, catch_ready=1, paddle_size=SIZE_DEF, speed_lvl=SPEED_DEF, hidden=shoot_en=sticky=multi_req=0, all five timers 0, active=0.
- All outputs are registered.
- FSM states:
  - IDLE: catch_ready=1. catch_valid & catch_ready latches catch_kind, then -> APPLY.
  - APPLY: catch_ready=0. Applies the latched effect on the clock edge, then -> IDLE.
  - A catch is accepted at most every 2 cycles; the effect is visible one cycle after the accept edge.
- Apply rules (all saturating, no wrap):
  - INC: size+1, clamped at 3. DEC: size-1, clamped at 0. Both reload the size timer to DURATION.
  - SPU: speed+1, clamped at 3. SPD: speed-1, clamped at 0. Both reload the speed timer.
  - HID, SOT, DRP: set hidden, shoot_en, sticky respectively and reload their own timer.
  - Re-catching an already active kind restarts its timer; levels accumulate (INC, INC from 1 gives 3).
  - MUL: multi_req=1 for exactly the APPLY cycle; no timer.
- Timers:
  - On frame_tick, every nonzero timer decrements by 1. A zero timer holds.
  - A decrement from 1 to 0 clears the effect on the same edge: size->SIZE_DEF, speed->SPEED_DEF, flag->0.
  - active[i] = (timer_i != 0).
  - If frame_tick coincides with APPLY reloading a timer, the reload wins; other timers still decrement.
- lost:
  - Highest priority. On any edge with lost=1: all effects return to reset values, timers clear, multi_req=0, FSM -> IDLE, and any latched or concurrent catch is discarded.
  - While lost is held high, catch_ready stays 1 but catches are ignored.
- Illegal states: an unreachable FSM encoding recovers to IDLE.
- catch_kind is sampled only on the accept edge; changes at other times have no effect.

Test Plan:
- Reset, DURATION=4: after reset release, paddle_size=1, speed_lvl=1, active=0, catch_ready=1.
- Catch INC (kind 0) -> catch_ready=0 for 1 cycle, then paddle_size=2, active=00001. Four frame_ticks later paddle_size=1, active=0.
- Back-to-back INC, INC, INC, DEC, each held until accepted -> sizes 2, 3, 3, 2. Size timer restarts at 4 on every catch.
- Catch MUL -> multi_req high for exactly 1 cycle, active unchanged. Then catch SOT and HID -> shoot_en=1, hidden=1, active=01100.
- SPD applied while frame_tick=1 and the speed timer=1 -> speed_lvl=0, speed timer=4; unrelated timers decrement.
- With sticky, hidden and size active, assert lost together with catch_valid (kind SPU) -> next cycle all defaults, active=0, speed_lvl=1 (SPU discarded).

Source files
------------

// File: rtl/gift_effect_scheduler.sv
// -----------------------------------------------------------------------------
// gift_effect_scheduler
//
// Applies power-up effects after the paddle catches a falling gift. One catch
// is taken at a time over a valid/ready handshake. Each effect class owns a
// frame-count timer. When the timer runs out, that effect returns to its default.
//
// Ports
//   clock        in   system clock
//   reset        in   asynchronous, active-high reset
//   frame_tick   in   one-cycle pulse per video frame
//   lost         in   ball lost; clears every effect (highest priority)
//   catch_valid  in   caught gift presented
//   catch_kind   in   [2:0] 0 INC,1 DEC,2 SPU,3 SPD,4 HID,5 SOT,6 DRP,7 MUL
//   catch_ready  out  scheduler can accept a catch
//   paddle_size  out  [1:0] paddle size level
//   speed_lvl    out  [1:0] ball speed level
//   hidden       out  ball invisible
//   shoot_en     out  paddle shooting enabled
//   sticky       out  ball sticks to paddle
//   multi_req    out  one-cycle request to spawn extra balls
//   active       out  [4:0] timer running: size, speed, hide, shoot, sticky
// -----------------------------------------------------------------------------
module gift_effect_scheduler #(
    parameter int         DURATION  = 600,
    parameter int         TMR_W     = 10,
    parameter logic [1:0] SIZE_DEF  = 2'd1,
    parameter logic [1:0] SPEED_DEF = 2'd1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       lost,
    input  logic       catch_valid,
    input  logic [2:0] catch_kind,
    output logic       catch_ready,
    output logic [1:0] paddle_size,
    output logic [1:0] speed_lvl,
    output logic       hidden,
    output logic       shoot_en,
    output logic       sticky,
    output logic       multi_req,
    output logic [4:0] active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01
    } state_t;

    typedef enum logic [2:0] {
        K_INC = 3'd0, K_DEC = 3'd1, K_SPU = 3'd2, K_SPD = 3'd3,
        K_HID = 3'd4, K_SOT = 3'd5, K_DRP = 3'd6, K_MUL = 3'd7
    } kind_t;

    localparam logic [TMR_W-1:0] LP_DUR = TMR_W'(DURATION);
    localparam logic [TMR_W-1:0] LP_ONE = TMR_W'(1);

    state_t                   r_state, w_next;
    kind_t                    r_kind;
    logic                     r_ready;
    logic [1:0]               r_size, r_speed;
    logic                     r_hidden, r_shoot, r_sticky, r_multi;
    logic [4:0][TMR_W-1:0]    r_tmr;
    logic [4:0][TMR_W-1:0]    w_tmr_nxt;
    logic [4:0]               r_active;
    logic [4:0]               w_reload;
    logic [4:0]               w_expire;
    logic                     w_accept;

    function automatic logic [1:0] lvl_up(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [1:0] lvl_down(input logic [1:0] v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

    // A concurrent lost discards the catch, even though ready still reads 1.
    assign w_accept = catch_valid && (r_state == ST_IDLE) && !lost;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_APPLY;
            ST_APPLY: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;   // unreachable encoding recovers
        endcase
        if (lost) w_next = ST_IDLE;
    end

    // Each timer that the effect applied in APPLY reloads.
    always_comb begin
        w_reload = '0;
        if (r_state == ST_APPLY) begin
            case (r_kind)
                K_INC, K_DEC: w_reload[0] = 1'b1;
                K_SPU, K_SPD: w_reload[1] = 1'b1;
                K_HID:        w_reload[2] = 1'b1;
                K_SOT:        w_reload[3] = 1'b1;
                K_DRP:        w_reload[4] = 1'b1;
                default:      ;
            endcase
        end
    end

    // Next timer values. A reload wins over a coincident frame tick, and an
    // expiry only counts when the timer is not being reloaded.
    always_comb begin
        w_tmr_nxt = r_tmr;
        w_expire  = '0;
        for (int i = 0; i < 5; i++) begin
            if (lost) begin
                w_tmr_nxt[i] = '0;
            end else if (w_reload[i]) begin
                w_tmr_nxt[i] = LP_DUR;
            end else if (frame_tick && (r_tmr[i] != '0)) begin
                w_tmr_nxt[i] = r_tmr[i] - LP_ONE;
                w_expire[i]  = (r_tmr[i] == LP_ONE);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_kind  <= K_INC;
            r_ready <= 1'b1;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ST_IDLE);
            if (w_accept) r_kind <= kind_t'(catch_kind);
            // Set on the accept edge, so the spawn request is high during the APPLY cycle only.
            r_multi <= w_accept && (kind_t'(catch_kind) == K_MUL);
        end
    end

    // NOTE: the timer array is a handful of registers, not a RAM, so it is reset with everything else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmr    <= '0;
            r_active <= '0;
            r_size   <= SIZE_DEF;
            r_speed  <= SPEED_DEF;
            r_hidden <= 1'b0;
            r_shoot  <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_tmr <= w_tmr_nxt;
            for (int i = 0; i < 5; i++) r_active[i] <= (w_tmr_nxt[i] != '0);

            if (lost)             r_size <= SIZE_DEF;
            else if (w_reload[0]) r_size <= (r_kind == K_INC) ? lvl_up(r_size) : lvl_down(r_size);
            else if (w_expire[0]) r_size <= SIZE_DEF;

            if (lost)             r_speed <= SPEED_DEF;
            else if (w_reload[1]) r_speed <= (r_kind == K_SPU) ? lvl_up(r_speed) : lvl_down(r_speed);
            else if (w_expire[1]) r_speed <= SPEED_DEF;

            if (lost)             r_hidden <= 1'b0;
            else if (w_reload[2]) r_hidden <= 1'b1;
            else if (w_expire[2]) r_hidden <= 1'b0;

            if (lost)             r_shoot <= 1'b0;
            else if (w_reload[3]) r_shoot <= 1'b1;
            else if (w_expire[3]) r_shoot <= 1'b0;

            if (lost)             r_sticky <= 1'b0;
            else if (w_reload[4]) r_sticky <= 1'b1;
            else if (w_expire[4]) r_sticky <= 1'b0;
        end
    end

    assign catch_ready = r_ready;
    assign paddle_size = r_size;
    assign speed_lvl   = r_speed;
    assign hidden      = r_hidden;
    assign shoot_en    = r_shoot;
    assign sticky      = r_sticky;
    assign multi_req   = r_multi;
    assign active      = r_active;

endmodule

// File: tb/tb_gift_effect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gift_effect_scheduler
//
// Directed bench for gift_effect_scheduler with DURATION=4. Inputs are driven
// and outputs are sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_gift_effect_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       lost = 1'b0;
    logic       catch_valid = 1'b0;
    logic [2:0] catch_kind = 3'd0;
    logic       catch_ready;
    logic [1:0] paddle_size;
    logic [1:0] speed_lvl;
    logic       hidden;
    logic       shoot_en;
    logic       sticky;
    logic       multi_req;
    logic [4:0] active;

    int total = 0;
    int bad   = 0;

    gift_effect_scheduler #(
        .DURATION (4),
        .TMR_W    (10),
        .SIZE_DEF (2'd1),
        .SPEED_DEF(2'd1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .lost       (lost),
        .catch_valid(catch_valid),
        .catch_kind (catch_kind),
        .catch_ready(catch_ready),
        .paddle_size(paddle_size),
        .speed_lvl  (speed_lvl),
        .hidden     (hidden),
        .shoot_en   (shoot_en),
        .sticky     (sticky),
        .multi_req  (multi_req),
        .active     (active)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Presents one catch, waits (bounded) for ready, then returns in the APPLY cycle.
    task automatic do_catch(input logic [2:0] kind);
        int n = 0;
        catch_valid = 1'b1;
        catch_kind  = kind;
        while (catch_ready !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        total++;
        if (catch_ready !== 1'b1) begin
            bad++;
            $display("FAIL catch_wait kind=%0d got_ready=%b want=1", kind, catch_ready);
        end
        step();
        catch_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        total++; if (paddle_size !== 2'd1) begin bad++; $display("FAIL rst_size got=%0d want=1", paddle_size); end
        total++; if (speed_lvl !== 2'd1) begin bad++; $display("FAIL rst_speed got=%0d want=1", speed_lvl); end
        total++; if (active !== 5'b00000) begin bad++; $display("FAIL rst_active got=%b want=00000", active); end
        total++; if (catch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", catch_ready); end
        total++; if ({hidden, shoot_en, sticky, multi_req} !== 4'b0000) begin bad++;
            $display("FAIL rst_flags got=%b want=0000", {hidden, shoot_en, sticky, multi_req}); end
    endtask

    task automatic test_inc();
        do_catch(3'd0);
        total++; if (catch_ready !== 1'b0) begin bad++; $display("FAIL inc_ready_low got=%b want=0", catch_ready); end
        total++; if (paddle_size !== 2'd1) begin bad++; $display("FAIL inc_size_early got=%0d want=1", paddle_size); end
        step();
        total++; if (paddle_size !== 2'd2) begin bad++; $display("FAIL inc_size got=%0d want=2", paddle_size); end
        total++; if (active !== 5'b00001) begin bad++; $display("FAIL inc_active got=%b want=00001", active); end
        total++; if (catch_ready !== 1'b1) begin bad++; $display("FAIL inc_ready_back got=%b want=1", catch_ready); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (paddle_size !== 2'd2 || active !== 5'b00001) begin bad++;
            $display("FAIL inc_3ticks got=%0d/%b want=2/00001", paddle_size, active); end
        tick();
        total++; if (paddle_size !== 2'd1 || active !== 5'b00000) begin bad++;
            $display("FAIL inc_expire got=%0d/%b want=1/00000", paddle_size, active); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] kinds [4] = '{3'd0, 3'd0, 3'd0, 3'd1};
        logic [1:0] sizes [4] = '{2'd2, 2'd3, 2'd3, 2'd2};
        catch_valid = 1'b1;
        catch_kind  = kinds[0];
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (catch_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_low idx=%0d got=%b want=0", i, catch_ready); end
            // catch_kind moves on during APPLY; the latched kind must still apply
            if (i < 3) catch_kind = kinds[i+1];
            else       catch_valid = 1'b0;
            step();
            total++; if (paddle_size !== sizes[i]) begin bad++;
                $display("FAIL b2b_size idx=%0d got=%0d want=%0d", i, paddle_size, sizes[i]); end
        end
        for (int i = 0; i < 3; i++) tick();
        total++; if (paddle_size !== 2'd2 || active !== 5'b00001) begin bad++;
            $display("FAIL b2b_3ticks got=%0d/%b want=2/00001", paddle_size, active); end
        tick();
        total++; if (paddle_size !== 2'd1 || active !== 5'b00000) begin bad++;
            $display("FAIL b2b_expire got=%0d/%b want=1/00000", paddle_size, active); end
    endtask

    task automatic test_mul_flags();
        do_catch(3'd7);
        total++; if (multi_req !== 1'b1) begin bad++; $display("FAIL mul_high got=%b want=1", multi_req); end
        step();
        total++; if (multi_req !== 1'b0) begin bad++; $display("FAIL mul_low got=%b want=0", multi_req); end
        total++; if (active !== 5'b00000) begin bad++; $display("FAIL mul_active got=%b want=00000", active); end
        do_catch(3'd5);
        step();
        do_catch(3'd4);
        step();
        total++; if (shoot_en !== 1'b1 || hidden !== 1'b1) begin bad++;
            $display("FAIL flags_set got=%b%b want=11", shoot_en, hidden); end
        total++; if (active !== 5'b01100) begin bad++; $display("FAIL flags_active got=%b want=01100", active); end
    endtask

    // Entry: hide and shoot timers at 4.
    task automatic test_conflict();
        do_catch(3'd3);
        step();                      // speed 0, speed timer 4
        tick();                      // speed 3, hide 3, shoot 3
        do_catch(3'd5);
        step();                      // shoot 4
        tick();
        tick();                      // speed 1, hide 1, shoot 2
        do_catch(3'd3);
        frame_tick = 1'b1;           // coincides with the SPD apply edge
        step();
        frame_tick = 1'b0;
        total++; if (speed_lvl !== 2'd0) begin bad++; $display("FAIL coll_speed got=%0d want=0", speed_lvl); end
        total++; if (hidden !== 1'b0 || shoot_en !== 1'b1) begin bad++;
            $display("FAIL coll_flags got=hid%b/sot%b want=hid0/sot1", hidden, shoot_en); end
        total++; if (active !== 5'b01010) begin bad++; $display("FAIL coll_active got=%b want=01010", active); end
        tick();
        total++; if (shoot_en !== 1'b0 || active !== 5'b00010) begin bad++;
            $display("FAIL coll_shoot_exp got=%b/%b want=0/00010", shoot_en, active); end
        tick();
        tick();
        total++; if (speed_lvl !== 2'd0 || active !== 5'b00010) begin bad++;
            $display("FAIL coll_speed_held got=%0d/%b want=0/00010", speed_lvl, active); end
        tick();
        total++; if (speed_lvl !== 2'd1 || active !== 5'b00000) begin bad++;
            $display("FAIL coll_speed_exp got=%0d/%b want=1/00000", speed_lvl, active); end
    endtask

    task automatic test_lost();
        do_catch(3'd6);
        step();
        do_catch(3'd4);
        step();
        do_catch(3'd0);
        step();
        total++; if (active !== 5'b10101 || sticky !== 1'b1 || hidden !== 1'b1 || paddle_size !== 2'd2) begin bad++;
            $display("FAIL lost_setup got=%b/%b%b/%0d want=10101/11/2", active, sticky, hidden, paddle_size); end
        catch_valid = 1'b1;
        catch_kind  = 3'd2;
        lost        = 1'b1;
        step();
        lost        = 1'b0;
        catch_valid = 1'b0;
        total++; if (active !== 5'b00000) begin bad++; $display("FAIL lost_active got=%b want=00000", active); end
        total++; if (paddle_size !== 2'd1 || speed_lvl !== 2'd1) begin bad++;
            $display("FAIL lost_levels got=%0d/%0d want=1/1", paddle_size, speed_lvl); end
        total++; if ({hidden, shoot_en, sticky, multi_req} !== 4'b0000) begin bad++;
            $display("FAIL lost_flags got=%b want=0000", {hidden, shoot_en, sticky, multi_req}); end
        total++; if (catch_ready !== 1'b1) begin bad++; $display("FAIL lost_ready got=%b want=1", catch_ready); end
        step();
        total++; if (speed_lvl !== 2'd1 || active !== 5'b00000) begin bad++;
            $display("FAIL lost_spu_dropped got=%0d/%b want=1/00000", speed_lvl, active); end

        // Held lost: ready stays high, catches ignored
        lost        = 1'b1;
        catch_valid = 1'b1;
        catch_kind  = 3'd0;
        step();
        total++; if (catch_ready !== 1'b1) begin bad++; $display("FAIL lost_held_ready got=%b want=1", catch_ready); end
        step();
        lost        = 1'b0;
        catch_valid = 1'b0;
        step();
        total++; if (paddle_size !== 2'd1 || active !== 5'b00000) begin bad++;
            $display("FAIL lost_held_ignored got=%0d/%b want=1/00000", paddle_size, active); end

        // Lost during APPLY drops the latched catch
        do_catch(3'd0);
        lost = 1'b1;
        step();
        lost = 1'b0;
        total++; if (paddle_size !== 2'd1 || catch_ready !== 1'b1) begin bad++;
            $display("FAIL lost_apply got=%0d/%b want=1/1", paddle_size, catch_ready); end
        step();
        total++; if (paddle_size !== 2'd1 || active !== 5'b00000) begin bad++;
            $display("FAIL lost_apply_after got=%0d/%b want=1/00000", paddle_size, active); end
    endtask

    initial begin
        test_reset();
        test_inc();
        test_back_to_back();
        test_mul_flags();
        test_conflict();
        test_lost();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
